// File: rtl/div_pkg.sv
// Shared definitions for the sequential 16x8 restoring divider.
// Holds the FSM state encoding, fixed operand widths, the step count and
// the quotient saturation value. Imported by div_step and div_16x8_seq.
package div_pkg;
  localparam int W_DIVIDEND = 16;
  localparam int W_DIVISOR  = 8;
  localparam int N_STEPS    = 8;

  localparam logic [W_DIVISOR-1:0] Q_SAT = 8'hFF;

  // ROUND is only ever entered when DIV_ROUND_EN is defined.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } div_state_t;
endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration.
// Ports:
//   p       in  8  partial remainder (always < divisor)
//   sin     in  1  next dividend bit shifted in
//   divisor in  8  divisor
//   p_nx    out 8  partial remainder after the step
//   qbit    out 1  quotient bit produced by the step
module div_step
  import div_pkg::*;
(
  input  logic [W_DIVISOR-1:0] p,
  input  logic                 sin,
  input  logic [W_DIVISOR-1:0] divisor,
  output logic [W_DIVISOR-1:0] p_nx,
  output logic                 qbit
);
  logic [W_DIVISOR:0] t;

  assign t    = {p, sin};
  assign qbit = t >= {1'b0, divisor};
  // The true difference is < divisor, so it fits in 8 bits and the low
  // 8 bits of the modulo-256 subtraction are exact.
  assign p_nx = qbit ? (t[W_DIVISOR-1:0] - divisor) : t[W_DIVISOR-1:0];
endmodule

// File: rtl/div_16x8_seq.sv
// Sequential 16/8 unsigned restoring divider, one quotient bit per clock,
// valid/ready on both sides, no overlap between operations.
// Optional macro DIV_ROUND_EN adds a ROUND state that rounds the quotient
// half-up (saturating at 0xFF with ovf=1); remainder stays the truncation
// remainder.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (in_ready only in IDLE)
//   dividend [15:0]       unsigned dividend
//   divisor  [7:0]        unsigned divisor
//   out_valid / out_ready result handshake
//   quotient, remainder   8-bit results, held until handshake
//   ovf                   quotient overflow, divide-by-zero or round saturation
module div_16x8_seq
  import div_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [W_DIVIDEND-1:0] dividend,
  input  logic [W_DIVISOR-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [W_DIVISOR-1:0]  quotient,
  output logic [W_DIVISOR-1:0]  remainder,
  output logic                  ovf
);
  div_state_t state, state_nx;

  logic [W_DIVISOR-1:0] p, s, dvsr, p_nx;
  logic [2:0]           cnt;
  logic                 qbit, accept, ovf_in, last_step, hshk;

  // in_ready is a registered decode of IDLE, low while reset is asserted.
  assign accept    = in_ready & in_valid;
  // High dividend byte >= divisor means the quotient cannot fit in 8 bits;
  // also catches divisor == 0.
  assign ovf_in    = dividend[W_DIVIDEND-1:W_DIVISOR] >= divisor;
  assign last_step = cnt == 3'(N_STEPS-1);
  assign hshk      = out_valid & out_ready;

  div_step u_step (
    .p       (p),
    .sin     (s[W_DIVISOR-1]),
    .divisor (dvsr),
    .p_nx    (p_nx),
    .qbit    (qbit)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (accept) state_nx = ovf_in ? DONE : CALC;
      CALC:  if (last_step) begin
`ifdef DIV_ROUND_EN
        state_nx = ROUND;
`else
        state_nx = DONE;
`endif
      end
      ROUND: state_nx = DONE;
      DONE:  if (hshk) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      p         <= '0;
      s         <= '0;
      dvsr      <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      in_ready <= (state_nx == IDLE);
      case (state)
        IDLE: if (accept) begin
          dvsr <= divisor;
          if (ovf_in) begin
            quotient  <= Q_SAT;
            remainder <= '0;
            ovf       <= 1'b1;
            out_valid <= 1'b1;
          end else begin
            p   <= dividend[W_DIVIDEND-1:W_DIVISOR];
            s   <= dividend[W_DIVISOR-1:0];
            cnt <= '0;
          end
        end
        CALC: begin
          // s holds remaining dividend bits in its top, quotient bits fill from LSB.
          p   <= p_nx;
          s   <= {s[W_DIVISOR-2:0], qbit};
          cnt <= cnt + 3'd1;
`ifndef DIV_ROUND_EN
          if (last_step) begin
            quotient  <= {s[W_DIVISOR-2:0], qbit};
            remainder <= p_nx;
            ovf       <= 1'b0;
            out_valid <= 1'b1;
          end
`endif
        end
`ifdef DIV_ROUND_EN
        ROUND: begin
          remainder <= p;
          out_valid <= 1'b1;
          // 2*rem >= divisor: round half up, saturating.
          if ({p, 1'b0} >= {1'b0, dvsr}) begin
            if (s == Q_SAT) begin
              quotient <= Q_SAT;
              ovf      <= 1'b1;
            end else begin
              quotient <= s + 8'd1;
              ovf      <= 1'b0;
            end
          end else begin
            quotient <= s;
            ovf      <= 1'b0;
          end
        end
`endif
        DONE: if (hshk) out_valid <= 1'b0;
        default: ;
      endcase
    end
endmodule

// File: tb/tb_div_16x8_seq.sv
// Self-checking bench for div_16x8_seq: directed literal cases, a stall /
// back-to-back case, a mid-calculation reset, and randomized traffic, all
// compared against an arithmetic reference model.
module tb_div_16x8_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        ovf;

  typedef struct {
    int q;
    int r;
    int o;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   rdy_mode = 0;  // 0: always ready, 1: random, 2: held low
  int   last_q, last_r, last_o;
  bit   ov_prev = 1'b0;

  div_16x8_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tmo(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out (cycle %0d)", name, cyc);
  endtask

  // Reference: plain integer division; rounding and overflow from the rules.
  function automatic exp_t model(input int a, input int b, input int acc);
    exp_t e;
    int   q, r;
    if (b == 0 || a / b > 255) begin
      e.q = 255; e.r = 0; e.o = 1; e.cyc = acc;
    end else begin
      q = a / b;
      r = a % b;
      e.o = 0;
`ifdef DIV_ROUND_EN
      if (2 * r >= b) begin
        if (q == 255) e.o = 1;
        else q++;
      end
      e.cyc = acc + 9;
`else
      e.cyc = acc + 8;
`endif
      e.q = q; e.r = r;
    end
    return e;
  endfunction

  // Compare process: every cycle a result is presented it must match the
  // oldest outstanding expectation; first appearance also checks latency.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      exp_q.delete();
      ov_prev = 1'b0;
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_result: got out_valid=1 expected no result (cycle %0d)", cyc);
        end else begin
          e = exp_q[0];
          if (!ov_prev) chk("latency", cyc, e.cyc);
          chk("quotient", int'(quotient), e.q);
          chk("remainder", int'(remainder), e.r);
          chk("ovf", int'(ovf), e.o);
          chk("busy_in_ready", int'(in_ready), 0);
          if (out_ready) begin
            void'(exp_q.pop_front());
            last_q = quotient; last_r = remainder; last_o = ovf;
          end
        end
      end
      ov_prev = out_valid;
    end
  end

  task automatic accept_op(input logic [15:0] a, input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    dividend = a; divisor = b; in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tmo("accept_wait");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    exp_q.push_back(model(int'(a), int'(b), cyc));
    // Garbage while busy must be ignored.
    in_valid = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) tmo("wait_idle");
  endtask

  task automatic lit(input string name, input logic [15:0] a, input logic [7:0] b,
                     input int eq, input int er, input int eo);
    accept_op(a, b);
    wait_idle();
    chk({name, "_q"}, last_q, eq);
    chk({name, "_r"}, last_r, er);
    chk({name, "_ovf"}, last_o, eo);
  endtask

  initial begin
    logic [15:0] a;
    logic [7:0]  b;
    int          n;
    in_valid = 1'b0; dividend = '0; divisor = '0; out_ready = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_quotient", int'(quotient), 0);
    chk("rst_remainder", int'(remainder), 0);
    chk("rst_ovf", int'(ovf), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1 chk("post_rst_in_ready", int'(in_ready), 1);

    // Hand-computed anchors.
`ifdef DIV_ROUND_EN
    lit("d1000_7", 16'd1000, 8'd7, 143, 6, 0);
    lit("d00fe_ff", 16'h00FE, 8'hFF, 1, 254, 0);
    lit("d7fc0_80", 16'h7FC0, 8'h80, 255, 64, 1);
`else
    lit("d1000_7", 16'd1000, 8'd7, 142, 6, 0);
    lit("d00fe_ff", 16'h00FE, 8'hFF, 0, 254, 0);
    lit("d7fc0_80", 16'h7FC0, 8'h80, 255, 64, 0);
`endif
    lit("d0100_01", 16'h0100, 8'h01, 255, 0, 1);
    lit("d1234_00", 16'h1234, 8'h00, 255, 0, 1);
    lit("d7f80_80", 16'h7F80, 8'h80, 255, 0, 0);

    // Stall: out_ready low for several cycles, then a held request.
    rdy_mode = 2;
    accept_op(16'd1000, 8'd7);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) tmo("stall_wait");
    repeat (5) @(negedge clk);
    dividend = 16'h1234; divisor = 8'h56; in_valid = 1'b1; rdy_mode = 0;
    @(negedge clk);
    chk("stall_in_ready", int'(in_ready), 0);
    chk("stall_out_valid", int'(out_valid), 1);
    @(negedge clk);
    chk("hshk_out_valid", int'(out_valid), 0);
    chk("hshk_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    exp_q.push_back(model(32'h1234, 32'h56, cyc));
    in_valid = 1'b0;
    wait_idle();

    // Reset in the middle of a calculation.
    accept_op(16'd1000, 8'd7);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", int'(in_ready), 0);
    chk("midrst_out_valid", int'(out_valid), 0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_rel_in_ready", int'(in_ready), 1);
    chk("midrst_rel_out_valid", int'(out_valid), 0);
    repeat (12) @(negedge clk);
    lit("d65535_255", 16'hFFFF, 8'hFF, 255, 0, 1);

    // Random traffic with random back-pressure.
    rdy_mode = 1;
    for (int i = 0; i < 250; i++) begin
      b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      if ($urandom_range(0, 3) == 0 || b == 0) a = 16'($urandom);
      else a = 16'($urandom_range(0, int'(b) * 256 - 1));
      accept_op(a, b);
    end
    rdy_mode = 0;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
